// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared types for the instruction fetch / prefetch unit.
//   FETCH_ADDR_WIDTH : width of the address stored with each fetched word
//   OPC_32BIT        : low two bits of a parcel that mark a 32-bit instruction
//   fetch_entry_t    : one prefetch-queue entry {word address, raw 32-bit word}
package fetch_prefetch_unit_pkg;

  localparam int unsigned FETCH_ADDR_WIDTH = 32;
  localparam logic [1:0]  OPC_32BIT        = 2'b11;

  typedef struct packed {
    logic [FETCH_ADDR_WIDTH-1:0] addr;
    logic [31:0]                 word;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_unit_queue.sv
// Circular FIFO of fetch entries for the prefetch queue.
//   clk, rst    : clock, synchronous active-high reset
//   clear       : empties the queue (takes effect at the clock edge)
//   push, data  : write one entry at the tail
//   pop         : drop the head entry
//   head        : entry at the read pointer
//   head_next   : entry after the head (valid when count >= 2)
//   count       : number of stored entries
// Caller guarantees no push when full and no pop when empty.
module fetch_queue
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t data,
  input  logic         pop,
  output fetch_entry_t head,
  output fetch_entry_t head_next,
  output logic [CW-1:0] count
);

  fetch_entry_t  store [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // DEPTH is a power of two, so pointer overflow is the circular wrap.
  assign head      = store[rd_ptr];
  assign head_next = store[rd_ptr + PW'(1)];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Payload storage needs no reset; consumers qualify it with count.
  always_ff @(posedge clk) begin
    if (push && !clear && !rst) store[wr_ptr] <= data;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: issues word reads to program memory, buffers the
// returned words in a prefetch queue and aligns 16/32-bit RV32IC instructions
// (including ones that straddle a word boundary) towards decode.
//   clk, rst            : clock, synchronous active-high reset
//   hold_i              : flash mode, fetch parked at RESET_PC, nothing issued
//   redirect_i          : restart fetch at redirect_pc_i (bit 0 ignored)
//   imem_req_o/addr_o   : word-aligned read request
//   imem_rdata_i        : read data, one cycle after the request
//   instr_valid_o/ready_i : handshake towards decode
//   instr_o             : raw instruction, compressed ones zero-extended
//   instr_pc_o          : PC of instr_o
//   instr_compressed_o  : instr_o is a 16-bit instruction
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter bit                    ENABLE_C    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [31:0]           imem_rdata_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [31:0]           instr_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  output logic                  instr_compressed_o
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] RESET_WORD = {RESET_PC[ADDR_WIDTH-1:2], 2'b00};
  localparam logic                  RESET_OFF  = ENABLE_C & RESET_PC[1];

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic                  inflight;
  logic                  offset;
  logic                  offset_nxt;

  fetch_entry_t  q_head;
  fetch_entry_t  q_next;
  fetch_entry_t  push_data;
  logic [CW-1:0] q_count;
  logic          push;
  logic          pop;
  logic          flush;
  logic          handshake;

  logic [15:0]   parcel;
  logic          is32;
  logic          straddle;

  logic          unused_bits;
  assign unused_bits = ^{redirect_pc_i[0], q_next.addr, q_next.word[31:16]};

  assign flush = redirect_i | hold_i;

  // ---------------- request side ----------------
  // Credit is count + in-flight response; a pop in this cycle is not credited,
  // which keeps the queue from overflowing without a combinational pop path.
  always_comb begin
    imem_req_o  = !rst && !flush &&
                  ((int'(q_count) + int'(inflight)) < int'(QUEUE_DEPTH));
    imem_addr_o = fetch_pc;
  end

  // A response arriving during redirect/hold belongs to the old stream.
  assign push           = inflight && !flush && !rst;
  assign push_data.addr = FETCH_ADDR_WIDTH'(req_addr_q);
  assign push_data.word = imem_rdata_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_WORD;
      req_addr_q <= '0;
      inflight   <= 1'b0;
      offset     <= RESET_OFF;
    end else if (hold_i) begin
      fetch_pc <= RESET_WORD;
      inflight <= 1'b0;
      offset   <= RESET_OFF;
    end else if (redirect_i) begin
      fetch_pc <= {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
      inflight <= 1'b0;
      offset   <= ENABLE_C & redirect_pc_i[1];
    end else begin
      inflight <= imem_req_o;
      if (imem_req_o) begin
        req_addr_q <= fetch_pc;
        fetch_pc   <= fetch_pc + ADDR_WIDTH'(4);
      end
      if (handshake) offset <= offset_nxt;
    end
  end

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .data      (push_data),
    .pop       (pop),
    .head      (q_head),
    .head_next (q_next),
    .count     (q_count)
  );

  // ---------------- aligner ----------------
  always_comb begin
    parcel   = offset ? q_head.word[31:16] : q_head.word[15:0];
    is32     = !ENABLE_C || (parcel[1:0] == OPC_32BIT);
    straddle = offset && is32;
  end

  always_comb begin
    instr_valid_o      = 1'b0;
    instr_o            = '0;
    instr_pc_o         = '0;
    instr_compressed_o = 1'b0;
    if (!rst && !flush && (q_count != '0) && !(straddle && (q_count < CW'(2)))) begin
      instr_valid_o      = 1'b1;
      instr_pc_o         = ADDR_WIDTH'(q_head.addr) + ADDR_WIDTH'({offset, 1'b0});
      instr_compressed_o = !is32;
      if (!is32)         instr_o = {16'h0000, parcel};
      else if (straddle) instr_o = {q_next.word[15:0], q_head.word[31:16]};
      else               instr_o = q_head.word;
    end
  end

  // A compressed parcel flips the half-word pointer and pops when leaving the
  // upper half; a 32-bit instruction always consumes the head word while the
  // pointer stays where it was (a straddle lands in the upper half again).
  always_comb begin
    handshake  = instr_valid_o && instr_ready_i;
    offset_nxt = is32 ? offset : !offset;
    pop        = handshake && (is32 || offset);
  end

endmodule
